cordic_rotate_engine: RTL and testbench
=======================================

CORDIC_ROTATE_ENGINE -- requirements
Module: cordic_rotate_engine

Interface
REQ-001 SHALL: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL: angle_deg  input  7  first-quadrant angle, unsigned integer degrees 0..90.
REQ-005 SHALL: cos_sign_in  input  1  1 = negate final cos.
REQ-006 SHALL: sin_sign_in  input  1  1 = negate final sin.
REQ-007 SHALL: c_s_swap_in  input  1  1 = exchange cos/sin before sign application.
REQ-008 SHALL: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL: out_valid  output  1  one-cycle pulse when results update.
REQ-010 SHALL: cos_out  output  16  signed Q1.14 cosine result.
REQ-011 SHALL: sin_out  output  16  signed Q1.14 sine result.
REQ-012 SHALL: cos_sign_out, sin_sign_out, c_s_swap_out  output  1 each  flags captured at start, held with results.

Function
REQ-013 SHALL: states IDLE, ITER, DONE; IDLE->ITER on start; ITER->DONE after 16th iteration; DONE->IDLE unconditionally next cycle.
REQ-014 SHALL: on accepted start, capture angle_deg and the three flags; angle_deg > 90 saturates to 90.
REQ-015 SHALL: load x = 9949 (K in Q1.14), y = 0, z = angle_deg * 286 (deg->rad, Q2.14, 16-bit unsigned, max 25740), iteration index i = 0.
REQ-016 SHALL: each ITER cycle: d = sign of z; x -= d*(y>>>i); y += d*(x>>>i); z -= d*atan(2^-i); arithmetic shifts, 18-bit signed internal x/y to absorb growth.
REQ-017 SHALL: perform exactly 16 iterations (i = 0..15), one per cycle.
REQ-018 SHALL: on ITER->DONE edge, saturate x,y to 16-bit and register cos_out/sin_out; out_valid high during DONE only.
REQ-019 SHALL: latency: start sampled at edge 0 -> out_valid high for one cycle after edge 17; busy high after edges 0..17, low after edge 18.
REQ-020 SHALL: start while busy is ignored, no queuing; next start accepted at first IDLE cycle.
REQ-021 SHALL: cos_out/sin_out/flag outputs hold last result until next DONE.
REQ-022 SHALL: accuracy: |error| <= 4 LSB versus ideal value for all inputs 0..90.

Reset
REQ-023 SHALL: rst_n low forces state IDLE, busy 0, out_valid 0, cos_out 0, sin_out 0, all flag outputs 0, internal x/y/z/i 0, immediately and at any point including mid-ITER.
REQ-024 SHALL: after reset release, first start accepted on the first clk edge with start high.

Configuration
REQ-025 SHALL: macro CORDIC_QUADRANT_APPLY_EN defined: at DONE, swap x/y if c_s_swap, then negate cos if cos_sign, negate sin if sin_sign, before registering outputs.
REQ-026 SHALL: macro undefined: outputs are raw first-quadrant x/y; flags passed through unchanged on *_out ports for downstream display to apply.

Structure
REQ-027 SHALL: shared package cordic_pkg holds ITER_N=16, DATA_W=16, INT_W=18, K_Q14=9949, DEG2RAD_Q14=286, state enum, atan table (Q2.14: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0).
REQ-028 SHALL: atan lookup is a sub-module cordic_atan_rom (4-bit index in, 16-bit constant out, combinational).

Verification
REQ-029 SHALL: angle 0, flags 0, start -> out_valid 17 cycles later, cos_out 16384±4, sin_out 0±4.
REQ-030 SHALL: angle 45, flags 0 -> cos_out and sin_out both 11585±4.
REQ-031 SHALL: angle 30, cos_sign=1, swap=1 (120 deg), macro defined -> cos_out -8192±4, sin_out 14189±4; macro undefined -> 14189/8192, flags echoed.
REQ-032 SHALL: angle 100 -> saturated to 90: cos_out 0±4, sin_out 16384±4.
REQ-033 SHALL: second start at edge 5 while busy -> ignored, single out_valid pulse, results from first request.
REQ-034 SHALL: rst_n low at iteration 8 -> all outputs 0 immediately, no out_valid; new start after release completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation engine.
//   - Fixed-point widths, CORDIC gain and the degree-to-radian scale factor.
//   - FSM state enum and the packed quadrant-flag bundle.
//   - The arctangent table, in Q2.14 radians, indexed by iteration number.
//   - sat_data(): clamps an internal INT_W value to the DATA_W output range.
package cordic_pkg;

    localparam int ITER_N  = 16;
    localparam int DATA_W  = 16;
    localparam int INT_W   = 18;
    localparam int ANGLE_W = 7;
    localparam int CNT_W   = 5;

    localparam logic [ANGLE_W-1:0]      ANGLE_MAX   = 7'd90;
    localparam logic signed [INT_W-1:0] K_Q14       = 18'sd9949;
    localparam logic [DATA_W-1:0]       DEG2RAD_Q14 = 16'd286;
    localparam logic [CNT_W-1:0]        ITER_LAST   = 5'(ITER_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic cos_sign;
        logic sin_sign;
        logic c_s_swap;
    } quad_flags_t;

    // atan(2^-i) in Q2.14 radians; the last entry rounds to zero.
    localparam logic [DATA_W-1:0] ATAN_TAB [ITER_N] = '{
        16'd12868, 16'd7596, 16'd4014, 16'd2037,
        16'd1023,  16'd512,  16'd256,  16'd128,
        16'd64,    16'd32,   16'd16,   16'd8,
        16'd4,     16'd2,    16'd1,    16'd0
    };

    // Symmetric clamp (+/-32767) so a later negation can never overflow.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [INT_W-1:0] v);
        if (v > 18'sd32767) begin
            return 16'sd32767;
        end else if (v < -18'sd32767) begin
            return -16'sd32767;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup for the CORDIC iterations (purely combinational).
//   idx      : iteration index 0..15
//   atan_q14 : atan(2^-idx) in Q2.14 radians
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]        idx,
    output logic [DATA_W-1:0] atan_q14
);

    assign atan_q14 = ATAN_TAB[idx];

endmodule

// File: rtl/cordic_rotate_engine.sv
// Iterative CORDIC rotation producing cos/sin of a first-quadrant angle.
// One request is processed at a time: IDLE -> ITER (setup + 16 micro-rotations)
// -> DONE (one cycle, out_valid high) -> IDLE.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle request, only honoured in IDLE
//   angle_deg[6:0]       : angle in integer degrees, values above 90 clamp to 90
//   cos_sign_in, sin_sign_in, c_s_swap_in : quadrant flags captured with start
//   busy                 : high whenever the engine is not IDLE
//   out_valid            : one-cycle pulse while results are fresh (DONE)
//   cos_out, sin_out     : signed Q1.14 results, held until the next DONE
//   cos_sign_out, sin_sign_out, c_s_swap_out : flags belonging to the results
//
// Build option CORDIC_QUADRANT_APPLY_EN: when defined, the flags are applied
// (swap, then negate) before the results are registered; when undefined the
// raw first-quadrant values are output and the flags are only passed along.
module cordic_rotate_engine
    import cordic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ANGLE_W-1:0]       angle_deg,
    input  logic                     cos_sign_in,
    input  logic                     sin_sign_in,
    input  logic                     c_s_swap_in,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] cos_out,
    output logic signed [DATA_W-1:0] sin_out,
    output logic                     cos_sign_out,
    output logic                     sin_sign_out,
    output logic                     c_s_swap_out
);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           i_q, i_d;
    logic signed [INT_W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    quad_flags_t                flags_q, flags_d;
    quad_flags_t                flags_out_q, flags_out_d;
    logic signed [DATA_W-1:0]   cos_q, cos_d, sin_q, sin_d;

    logic [ANGLE_W-1:0]         angle_sat;
    logic [DATA_W-1:0]          z_load;
    logic [DATA_W-1:0]          atan_val;
    logic signed [INT_W-1:0]    atan_ext, x_sh, y_sh;
    logic signed [DATA_W-1:0]   cos_res, sin_res;

    cordic_atan_rom u_atan_rom (
        .idx      (i_q[3:0]),
        .atan_q14 (atan_val)
    );

    assign angle_sat = (angle_deg > ANGLE_MAX) ? ANGLE_MAX : angle_deg;
    assign z_load    = {{(DATA_W-ANGLE_W){1'b0}}, angle_sat} * DEG2RAD_Q14;
    assign atan_ext  = {{(INT_W-DATA_W){1'b0}}, atan_val};
    assign x_sh      = x_q >>> i_q[3:0];
    assign y_sh      = y_q >>> i_q[3:0];

`ifdef CORDIC_QUADRANT_APPLY_EN
    logic signed [DATA_W-1:0] cos_pre, sin_pre;
    assign cos_pre = flags_q.c_s_swap ? sat_data(y_q) : sat_data(x_q);
    assign sin_pre = flags_q.c_s_swap ? sat_data(x_q) : sat_data(y_q);
    assign cos_res = flags_q.cos_sign ? -cos_pre : cos_pre;
    assign sin_res = flags_q.sin_sign ? -sin_pre : sin_pre;
`else
    assign cos_res = sat_data(x_q);
    assign sin_res = sat_data(y_q);
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        flags_d     = flags_q;
        flags_out_d = flags_out_q;
        cos_d       = cos_q;
        sin_d       = sin_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    i_d     = '0;
                    x_d     = K_Q14;
                    y_d     = '0;
                    z_d     = {{(INT_W-DATA_W){1'b0}}, z_load};
                    flags_d = '{cos_sign: cos_sign_in, sin_sign: sin_sign_in, c_s_swap: c_s_swap_in};
                end
            end
            ITER: begin
                // i counts 0..15 for the rotations; i == 16 is the extra cycle
                // that latches the results and moves to DONE.
                if (i_q == ITER_LAST) begin
                    state_d     = DONE;
                    cos_d       = cos_res;
                    sin_d       = sin_res;
                    flags_out_d = flags_q;
                end else begin
                    // Rotate towards z = 0; z >= 0 counts as positive direction.
                    if (!z_q[INT_W-1]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_ext;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_ext;
                    end
                    i_d = i_q + 5'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            flags_q     <= '0;
            flags_out_q <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            flags_out_q <= flags_out_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == DONE);
    assign cos_out      = cos_q;
    assign sin_out      = sin_q;
    assign cos_sign_out = flags_out_q.cos_sign;
    assign sin_sign_out = flags_out_q.sin_sign;
    assign c_s_swap_out = flags_out_q.c_s_swap;

endmodule

// File: tb/tb_cordic_rotate_engine.sv
// Directed bench for cordic_rotate_engine. Inputs change and outputs are
// sampled on the falling clock edge. Expected values are fixed constants
// with a +/-4 LSB tolerance on the cos/sin results.
module tb_cordic_rotate_engine;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [6:0]         angle_deg;
    logic               cos_sign_in, sin_sign_in, c_s_swap_in;
    logic               busy, out_valid;
    logic signed [15:0] cos_out, sin_out;
    logic               cos_sign_out, sin_sign_out, c_s_swap_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cordic_rotate_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .angle_deg    (angle_deg),
        .cos_sign_in  (cos_sign_in),
        .sin_sign_in  (sin_sign_in),
        .c_s_swap_in  (c_s_swap_in),
        .busy         (busy),
        .out_valid    (out_valid),
        .cos_out      (cos_out),
        .sin_out      (sin_out),
        .cos_sign_out (cos_sign_out),
        .sin_sign_out (sin_sign_out),
        .c_s_swap_out (c_s_swap_out)
    );

    // Presents a request so that start is sampled at the next rising edge
    // ("edge 0"); returns on the falling edge right after it.
    task automatic launch(input logic [6:0] ang, input logic cs, input logic ss, input logic sw);
        @(negedge clk);
        angle_deg   = ang;
        cos_sign_in = cs;
        sin_sign_in = ss;
        c_s_swap_in = sw;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the edge number (relative to edge 0) after which out_valid is
    // first seen; gives up at 40.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        angle_deg   = '0;
        cos_sign_in = 1'b0;
        sin_sign_in = 1'b0;
        c_s_swap_in = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (cos_out !== 16'sd0) begin n_fail++; $display("FAIL reset_cos: got %0d expected 0", cos_out); end
        n_cmp++; if (sin_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sin: got %0d expected 0", sin_out); end
        n_cmp++; if ({cos_sign_out, sin_sign_out, c_s_swap_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {cos_sign_out, sin_sign_out, c_s_swap_out});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_angle_zero();
        int lat;
        launch(7'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a0_busy_after_edge0: got %b expected 1", busy); end
        wait_valid(lat);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL a0_latency: got %0d expected 17", lat); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a0_busy_in_done: got %b expected 1", busy); end
        n_cmp++; if (int'(cos_out) < 16380 || int'(cos_out) > 16388) begin
            n_fail++; $display("FAIL a0_cos: got %0d expected 16384+-4", cos_out);
        end
        n_cmp++; if (int'(sin_out) < -4 || int'(sin_out) > 4) begin
            n_fail++; $display("FAIL a0_sin: got %0d expected 0+-4", sin_out);
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL a0_valid_one_cycle: got %b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a0_busy_after_edge18: got %b expected 0", busy); end
    endtask

    task automatic test_angle_45();
        int lat;
        launch(7'd45, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL a45_latency: got %0d expected 17", lat); end
        n_cmp++; if (int'(cos_out) < 11581 || int'(cos_out) > 11589) begin
            n_fail++; $display("FAIL a45_cos: got %0d expected 11585+-4", cos_out);
        end
        n_cmp++; if (int'(sin_out) < 11581 || int'(sin_out) > 11589) begin
            n_fail++; $display("FAIL a45_sin: got %0d expected 11585+-4", sin_out);
        end
    endtask

    task automatic test_saturate_hold();
        int lat;
        launch(7'd100, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL sat_latency: got %0d expected 17", lat); end
        n_cmp++; if (int'(cos_out) < -4 || int'(cos_out) > 4) begin
            n_fail++; $display("FAIL sat_cos: got %0d expected 0+-4", cos_out);
        end
        n_cmp++; if (int'(sin_out) < 16380 || int'(sin_out) > 16388) begin
            n_fail++; $display("FAIL sat_sin: got %0d expected 16384+-4", sin_out);
        end
        // Inputs move without a start: results must stay put.
        angle_deg   = 7'd0;
        cos_sign_in = 1'b1;
        repeat (5) @(negedge clk);
        cos_sign_in = 1'b0;
        n_cmp++; if (int'(sin_out) < 16380 || int'(sin_out) > 16388) begin
            n_fail++; $display("FAIL hold_sin: got %0d expected 16384+-4", sin_out);
        end
        n_cmp++; if (int'(cos_out) < -4 || int'(cos_out) > 4) begin
            n_fail++; $display("FAIL hold_cos: got %0d expected 0+-4", cos_out);
        end
        n_cmp++; if (cos_sign_out !== 1'b0) begin n_fail++; $display("FAIL hold_cos_sign: got %b expected 0", cos_sign_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int pulses    = 0;
        int first_k   = -1;
        int cos_first = 0;
        int sin_first = 0;
        launch(7'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                pulses++;
                if (first_k < 0) begin
                    first_k   = k;
                    cos_first = int'(cos_out);
                    sin_first = int'(sin_out);
                end
            end
            if (k == 4) begin
                angle_deg = 7'd45;
                start     = 1'b1;
            end
            if (k == 5) start = 1'b0;
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (first_k != 17) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 17", first_k); end
        n_cmp++; if (cos_first < 16380 || cos_first > 16388) begin
            n_fail++; $display("FAIL b2b_cos: got %0d expected 16384+-4", cos_first);
        end
        n_cmp++; if (sin_first < -4 || sin_first > 4) begin
            n_fail++; $display("FAIL b2b_sin: got %0d expected 0+-4", sin_first);
        end
    endtask

    task automatic test_quadrant_flags();
        int lat;
        int exp_cos;
        int exp_sin;
`ifdef CORDIC_QUADRANT_APPLY_EN
        exp_cos = -8192;
        exp_sin = 14189;
`else
        exp_cos = 14189;
        exp_sin = 8192;
`endif
        launch(7'd30, 1'b1, 1'b0, 1'b1);
        wait_valid(lat);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL q120_latency: got %0d expected 17", lat); end
        n_cmp++; if (int'(cos_out) < exp_cos - 4 || int'(cos_out) > exp_cos + 4) begin
            n_fail++; $display("FAIL q120_cos: got %0d expected %0d+-4", cos_out, exp_cos);
        end
        n_cmp++; if (int'(sin_out) < exp_sin - 4 || int'(sin_out) > exp_sin + 4) begin
            n_fail++; $display("FAIL q120_sin: got %0d expected %0d+-4", sin_out, exp_sin);
        end
        n_cmp++; if ({cos_sign_out, sin_sign_out, c_s_swap_out} !== 3'b101) begin
            n_fail++; $display("FAIL q120_flags: got %b expected 101", {cos_sign_out, sin_sign_out, c_s_swap_out});
        end
    endtask

    task automatic test_reset_mid_iter();
        int lat;
        int pulses = 0;
        launch(7'd45, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (cos_out !== 16'sd0) begin n_fail++; $display("FAIL midrst_cos: got %0d expected 0", cos_out); end
        n_cmp++; if (sin_out !== 16'sd0) begin n_fail++; $display("FAIL midrst_sin: got %0d expected 0", sin_out); end
        n_cmp++; if ({cos_sign_out, sin_sign_out, c_s_swap_out} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 000", {cos_sign_out, sin_sign_out, c_s_swap_out});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", pulses); end
        launch(7'd0, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 17", lat); end
        n_cmp++; if (int'(cos_out) < 16380 || int'(cos_out) > 16388) begin
            n_fail++; $display("FAIL postrst_cos: got %0d expected 16384+-4", cos_out);
        end
        n_cmp++; if (int'(sin_out) < -4 || int'(sin_out) > 4) begin
            n_fail++; $display("FAIL postrst_sin: got %0d expected 0+-4", sin_out);
        end
    endtask

    initial begin
        test_reset();
        test_angle_zero();
        test_angle_45();
        test_saturate_hold();
        test_back_to_back();
        test_quadrant_flags();
        test_reset_mid_iter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
